// File: rtl/mc_mem_responder_if.sv
// Request/response bundle between the multicycle controller/datapath and the
// unified memory responder.
interface mc_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Busy;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemErr, Busy
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemErr, Busy
  );
endinterface

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory for the multicycle MIPS core: accepts one
// request in IDLE, waits LAT cycles, performs the access and pulses MemReady.
module mc_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_mem_responder_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              acc_en;
  logic              req;
  logic              req_err;

  logic [31:0] mem [2**ADDR_W];

  assign req     = bus.MemRead | bus.MemWrite;
  assign req_err = (bus.MemRead & bus.MemWrite)
                 | (bus.Addr[1:0] != 2'b00)
                 | (bus.Addr[31:ADDR_W+2] != '0);

  // The _d copies of the request fields double as the access operands: on an
  // accepting IDLE edge they carry the live inputs, in WAIT the latched ones.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    acc_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = bus.Addr[ADDR_W+1:2];
          wdata_d = bus.WriteData;
          we_d    = bus.MemWrite;
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          if (LAT == 1) begin
            acc_en  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (acc_en && !we_d && !err_d) rdata_d = mem[idx_d];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the write is gated by
  // rst_n instead, so an access caught by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (rst_n && acc_en && we_d && !err_d) mem[idx_d] <= wdata_d;
  end

  assign bus.ReadData = rdata_q;
  assign bus.MemReady = (state_q == S_DONE);
  assign bus.MemErr   = (state_q == S_DONE) & err_q;
  assign bus.Busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder: a LAT=2 instance for the main flows and
// a LAT=1 instance for the zero-wait path.
module tb_mc_mem_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mc_mem_responder_if bus1 ();
  mc_mem_responder_if bus2 ();

  mc_mem_responder #(.ADDR_W(8), .LAT(2)) dut_lat2 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mc_mem_responder #(.ADDR_W(8), .LAT(1)) dut_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on the LAT=2 instance; MemReady must appear at the third
  // falling edge after the accepting rising edge.
  task automatic access2(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rd, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus1.MemRead   = rd;
    bus1.MemWrite  = wr;
    bus1.Addr      = addr;
    bus1.WriteData = wdata;
    @(posedge clk);
    #1;
    bus1.MemRead  = 1'b0;
    bus1.MemWrite = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, "_busy"}, bus1.Busy, 32'd1);
      if (bus1.MemReady) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_err"}, bus1.MemErr, exp_err);
    check({tag, "_rdata"}, bus1.ReadData, exp_rd);
  endtask

  // One request on the LAT=1 instance: straight to DONE, Busy never seen.
  task automatic access1(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input string tag);
    int   lat;
    logic busy_seen;
    lat       = 0;
    busy_seen = 1'b0;
    @(negedge clk);
    bus2.MemRead   = rd;
    bus2.MemWrite  = wr;
    bus2.Addr      = addr;
    bus2.WriteData = wdata;
    @(posedge clk);
    #1;
    bus2.MemRead  = 1'b0;
    bus2.MemWrite = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus2.Busy;
      if (bus2.MemReady) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, 32'd1);
    check({tag, "_busy"}, busy_seen, 32'd0);
    check({tag, "_err"}, bus2.MemErr, 32'd0);
    check({tag, "_rdata"}, bus2.ReadData, exp_rd);
  endtask

  initial begin
    int pulses;
    int seen;
    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus1.MemRead   = 1'b0;
    bus1.MemWrite  = 1'b0;
    bus1.Addr      = 32'd0;
    bus1.WriteData = 32'd0;
    bus2.MemRead   = 1'b0;
    bus2.MemWrite  = 1'b0;
    bus2.Addr      = 32'd0;
    bus2.WriteData = 32'd0;

    // Reset, then idle with no requests.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      check("rst_rdata", bus1.ReadData, 32'd0);
      check("rst_ready", bus1.MemReady, 32'd0);
      check("rst_err",   bus1.MemErr,   32'd0);
      check("rst_busy",  bus1.Busy,     32'd0);
    end

    // Write then read back with LAT=2 timing.
    access2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "wr10");
    access2(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "rd10");

    // Error cases leave array and ReadData untouched.
    access2(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, "wr20");
    access2(1'b1, 1'b1, 32'h20, 32'h11111111, 1'b1, 32'hDEADBEEF, "both20");
    access2(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, "rd20");
    access2(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'hCAFEF00D, "misalign");
    access2(1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 1'b0, 32'hCAFEF00D, "wr00");
    access2(1'b0, 1'b1, 32'h400, 32'h55555555, 1'b1, 32'hCAFEF00D, "range400");
    access2(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0BADC0DE, "rd00");

    // Read held high: accepted only from IDLE, pulses at falling edges 3, 7, 11.
    @(negedge clk);
    bus1.Addr    = 32'h0;
    bus1.MemRead = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus1.MemReady) begin
        pulses++;
        check("held_pos", c, 3 + 4 * (pulses - 1));
        check("held_rdata", bus1.ReadData, 32'h0BADC0DE);
      end
    end
    bus1.MemRead = 1'b0;
    check("held_count", pulses, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("held_idle_busy", bus1.Busy, 32'd0);

    // Reset during a write's WAIT abandons it.
    access2(1'b0, 1'b1, 32'h8, 32'hAAAA0008, 1'b0, 32'h0BADC0DE, "wr08");
    @(negedge clk);
    bus1.MemWrite  = 1'b1;
    bus1.Addr      = 32'h8;
    bus1.WriteData = 32'h00001234;
    @(posedge clk);
    #1;
    bus1.MemWrite = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus1.Busy, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", bus1.MemReady, 32'd0);
    check("midrst_rdata", bus1.ReadData, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus1.MemReady) seen++;
    end
    check("midrst_noready", seen, 32'd0);
    access2(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hAAAA0008, "rd08");

    // Zero-wait instance.
    access1(1'b0, 1'b1, 32'h4, 32'h600DF00D, 32'h0, "l1_wr04");
    access1(1'b1, 1'b0, 32'h4, 32'h0, 32'h600DF00D, "l1_rd04");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
